systolic_tile_controller: RTL and testbench

- Parametrised sequencer for an N×N output-stationary systolic array.
- Loads A/B operand rows one row per handshake and steps the array for N cycles per K-tile.
- Accumulates across a programmable number of K-tiles, then drains the array into the C buffer.
- Streams the N result rows out over a valid/ready interface; sits between the operand/result buffers and the PE grid.

---
 rtl/systolic_tile_controller_if.sv | 51 +++++
 rtl/systolic_tile_controller.sv | 136 +++++++++++++
 tb/tb_systolic_tile_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_tile_controller_if.sv
// Handshake and control bundle between the systolic tile controller and its buffers/PE grid.
// The abort/aborted pair exists only when SYSTOLIC_CTRL_ABORT_EN is defined.
interface systolic_tile_controller_if #(
  parameter int unsigned ROW_W  = 3,
  parameter int unsigned TILE_W = 4
) ();
  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              ready;
  logic              busy;
  logic              done;
  logic              a_valid;
  logic              a_ready;
  logic              b_valid;
  logic              b_ready;
  logic              input_write;
  logic [ROW_W-1:0]  row_ptr;
  logic              acc_clear;
  logic              enable;
  logic              output_write;
  logic              c_valid;
  logic              c_ready;
  logic [ROW_W-1:0]  c_row_ptr;
  logic              c_last;
`ifdef SYSTOLIC_CTRL_ABORT_EN
  logic              abort;
  logic              aborted;

  modport master (
    input  start, num_tiles, a_valid, b_valid, c_ready, abort,
    output ready, busy, done, a_ready, b_ready, input_write, row_ptr,
           acc_clear, enable, output_write, c_valid, c_row_ptr, c_last, aborted
  );
  modport slave (
    output start, num_tiles, a_valid, b_valid, c_ready, abort,
    input  ready, busy, done, a_ready, b_ready, input_write, row_ptr,
           acc_clear, enable, output_write, c_valid, c_row_ptr, c_last, aborted
  );
`else
  modport master (
    input  start, num_tiles, a_valid, b_valid, c_ready,
    output ready, busy, done, a_ready, b_ready, input_write, row_ptr,
           acc_clear, enable, output_write, c_valid, c_row_ptr, c_last
  );
  modport slave (
    output start, num_tiles, a_valid, b_valid, c_ready,
    input  ready, busy, done, a_ready, b_ready, input_write, row_ptr,
           acc_clear, enable, output_write, c_valid, c_row_ptr, c_last
  );
`endif
endinterface

// File: rtl/systolic_tile_controller.sv
// Sequencer for an N x N output-stationary systolic array: load, compute per K-tile, drain, stream out.
// Optional job cancellation is compiled in with SYSTOLIC_CTRL_ABORT_EN.
module systolic_tile_controller #(
  parameter int unsigned N      = 8,
  parameter int unsigned ROW_W  = $clog2(N),
  parameter int unsigned TILE_W = 4
) (
  input logic                        clk,
  input logic                        rst,
  systolic_tile_controller_if.master bus_if
);
  localparam int unsigned        DRAIN_W    = $clog2(2 * N);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_OUTPUT, S_DONE
  } state_e;

  state_e             state_q;
  logic [ROW_W-1:0]   row_cnt_q;
  logic [ROW_W-1:0]   cmp_cnt_q;
  logic [ROW_W-1:0]   out_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [TILE_W-1:0]  tile_cnt_q;
  logic [TILE_W-1:0]  tiles_q;
  logic               abort_hit;
  logic               row_accept;

`ifdef SYSTOLIC_CTRL_ABORT_EN
  assign abort_hit      = bus_if.abort && (state_q != S_IDLE);
  assign bus_if.aborted = abort_hit;
`else
  assign abort_hit = 1'b0;
`endif

  assign row_accept = (state_q == S_LOAD) && bus_if.a_valid && bus_if.b_valid;

  // State and counters; an abort wins over normal sequencing in any busy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tile_cnt_q  <= '0;
      tiles_q     <= '0;
    end else if (abort_hit) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tile_cnt_q  <= '0;
      tiles_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            state_q    <= S_LOAD;
            tiles_q    <= (bus_if.num_tiles == '0) ? TILE_W'(1) : bus_if.num_tiles;
            row_cnt_q  <= '0;
            tile_cnt_q <= '0;
          end
        end
        S_LOAD: begin
          if (row_accept) begin
            if (row_cnt_q == ROW_LAST) begin
              row_cnt_q <= '0;
              state_q   <= S_COMPUTE;
            end else begin
              row_cnt_q <= row_cnt_q + ROW_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (cmp_cnt_q == ROW_LAST) begin
            cmp_cnt_q <= '0;
            if (tile_cnt_q < (tiles_q - TILE_W'(1))) begin
              tile_cnt_q <= tile_cnt_q + TILE_W'(1);
              state_q    <= S_LOAD;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            cmp_cnt_q <= cmp_cnt_q + ROW_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            drain_cnt_q <= '0;
            state_q     <= S_OUTPUT;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end
        S_OUTPUT: begin
          if (bus_if.c_ready) begin
            if (out_cnt_q == ROW_LAST) begin
              out_cnt_q <= '0;
              state_q   <= S_DONE;
            end else begin
              out_cnt_q <= out_cnt_q + ROW_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          row_cnt_q   <= '0;
          cmp_cnt_q   <= '0;
          out_cnt_q   <= '0;
          drain_cnt_q <= '0;
          tile_cnt_q  <= '0;
          tiles_q     <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state and counters.
  assign bus_if.ready        = (state_q == S_IDLE);
  assign bus_if.busy         = (state_q != S_IDLE);
  assign bus_if.done         = (state_q == S_DONE) && !abort_hit;
  assign bus_if.a_ready      = (state_q == S_LOAD) && !abort_hit;
  assign bus_if.b_ready      = (state_q == S_LOAD) && !abort_hit;
  assign bus_if.input_write  = row_accept && !abort_hit;
  assign bus_if.row_ptr      = row_cnt_q;
  assign bus_if.acc_clear    = (state_q == S_IDLE) && bus_if.start && !rst;
  assign bus_if.enable       = ((state_q == S_COMPUTE) || (state_q == S_DRAIN)) && !abort_hit;
  assign bus_if.output_write = (state_q == S_DRAIN) && !abort_hit;
  assign bus_if.c_valid      = (state_q == S_OUTPUT) && !abort_hit;
  assign bus_if.c_row_ptr    = out_cnt_q;
  assign bus_if.c_last       = (state_q == S_OUTPUT) && !abort_hit && (out_cnt_q == ROW_LAST);
endmodule

// File: tb/tb_systolic_tile_controller.sv
// Bench for systolic_tile_controller: builds an expected per-cycle output timeline from the job
// description (tile count, input gaps, output stalls) and compares the DUT against it every cycle.
`timescale 1ns/1ps
module tb_systolic_tile_controller;
  localparam int unsigned N      = 8;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned TILE_W = 4;
  localparam int          MAXC   = 512;
  localparam logic [16:0] IDLE_V = 17'b1_0000000000000000;
  localparam logic [16:0] ABORT_MASK = 17'b1_1_0_0_0_0_111_1_0_0_0_111_0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  systolic_tile_controller_if #(.ROW_W(ROW_W), .TILE_W(TILE_W)) bus_if ();
  systolic_tile_controller #(.N(N), .ROW_W(ROW_W), .TILE_W(TILE_W)) dut (
    .clk(clk), .rst(rst), .bus_if(bus_if)
  );

  always #5 clk = ~clk;

  logic [16:0]       exp_v [MAXC];
  bit                d_a   [MAXC];
  bit                d_b   [MAXC];
  bit                d_c   [MAXC];
  bit                d_st  [MAXC];
  logic [TILE_W-1:0] d_nt  [MAXC];
  int                gap_a [8][N];
  int                gap_c [N];
  int                job_len;
  int                exp_done_t;

  // {ready,busy,done,a_ready,b_ready,input_write,row_ptr,acc_clear,enable,output_write,c_valid,c_row_ptr,c_last}
  function automatic logic [16:0] vec(bit rdy, bit bsy, bit dn, bit ld, bit iw, int rp, bit acc,
                                      bit en, bit ow, bit cv, int cr, bit cl);
    return {rdy, bsy, dn, ld, ld, iw, 3'(rp), acc, en, ow, cv, 3'(cr), cl};
  endfunction

  function automatic void clear_gaps();
    for (int k = 0; k < 8; k++) for (int r = 0; r < N; r++) gap_a[k][r] = 0;
    for (int r = 0; r < N; r++) gap_c[r] = 0;
  endfunction

  function automatic void random_gaps();
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < N; r++)
        gap_a[k][r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    for (int r = 0; r < N; r++)
      gap_c[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Expected timeline: start cycle, per tile N loaded rows (+gaps) and N compute cycles,
  // 2N-1 drain cycles, N delivered rows (+stalls), one done cycle, then idle.
  function automatic void build(int tiles_n);
    int t;
    int eff;
    int mode;
    eff = (tiles_n == 0) ? 1 : tiles_n;
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i] = IDLE_V;
      d_a[i]   = bit'($urandom_range(0, 1));
      d_b[i]   = bit'($urandom_range(0, 1));
      d_c[i]   = bit'($urandom_range(0, 1));
      d_st[i]  = bit'($urandom_range(0, 1));
      d_nt[i]  = TILE_W'($urandom_range(0, 15));
    end
    d_st[0]  = 1'b1;
    d_nt[0]  = TILE_W'(tiles_n);
    exp_v[0] = vec(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    t = 1;
    for (int k = 0; k < eff; k++) begin
      for (int r = 0; r < N; r++) begin
        for (int g = 0; g < gap_a[k][r]; g++) begin
          mode = int'($urandom_range(0, 2));
          d_a[t] = (mode == 1);
          d_b[t] = (mode == 2);
          exp_v[t] = vec(0, 1, 0, 1, 0, r, 0, 0, 0, 0, 0, 0);
          t++;
        end
        d_a[t] = 1'b1;
        d_b[t] = 1'b1;
        exp_v[t] = vec(0, 1, 0, 1, 1, r, 0, 0, 0, 0, 0, 0);
        t++;
      end
      for (int c = 0; c < N; c++) begin
        exp_v[t] = vec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        t++;
      end
    end
    for (int c = 0; c < 2 * N - 1; c++) begin
      exp_v[t] = vec(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      t++;
    end
    for (int r = 0; r < N; r++) begin
      for (int g = 0; g < gap_c[r]; g++) begin
        d_c[t] = 1'b0;
        exp_v[t] = vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, r, r == N - 1);
        t++;
      end
      d_c[t] = 1'b1;
      exp_v[t] = vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, r, r == N - 1);
      t++;
    end
    exp_v[t]   = vec(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    d_st[t]    = 1'b0;
    exp_done_t = t;
    t++;
    exp_v[t] = IDLE_V;
    d_st[t]  = 1'b0;
    job_len  = t + 1;
  endfunction

  // cut_kind: 0 = run to completion, 1 = reset at cut_at, 2 = abort at cut_at.
  task automatic run_job(int cut_at, int cut_kind, int want_done);
    logic [16:0] e;
    logic [16:0] obs;
    bit          ab_e;
    int          done_seen;
    done_seen = -1;
    for (int t = 0; t < job_len; t++) begin
      @(posedge clk);
      #1;
      bus_if.start     = d_st[t];
      bus_if.num_tiles = d_nt[t];
      bus_if.a_valid   = d_a[t];
      bus_if.b_valid   = d_b[t];
      bus_if.c_ready   = d_c[t];
      e    = exp_v[t];
      ab_e = 1'b0;
      if (cut_kind == 1 && t == cut_at) begin
        rst = 1'b1;
        bus_if.start = 1'b0;
        e = IDLE_V;
      end
`ifdef SYSTOLIC_CTRL_ABORT_EN
      if (cut_kind == 2 && t == cut_at) begin
        bus_if.abort = 1'b1;
        e    = e & ABORT_MASK;
        ab_e = 1'b1;
      end
`endif
      @(negedge clk);
      obs = {bus_if.ready, bus_if.busy, bus_if.done, bus_if.a_ready, bus_if.b_ready,
             bus_if.input_write, bus_if.row_ptr, bus_if.acc_clear, bus_if.enable,
             bus_if.output_write, bus_if.c_valid, bus_if.c_row_ptr, bus_if.c_last};
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL outputs cycle=%0d observed=%b expected=%b", t, obs, e);
      end
`ifdef SYSTOLIC_CTRL_ABORT_EN
      checks++;
      assert (bus_if.aborted === ab_e) else begin
        failures++;
        $error("FAIL aborted cycle=%0d observed=%b expected=%b", t, bus_if.aborted, ab_e);
      end
`endif
      if (bus_if.done === 1'b1 && done_seen < 0) done_seen = t;
      if (cut_kind != 0 && t == cut_at) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.start = 1'b0;
`ifdef SYSTOLIC_CTRL_ABORT_EN
        bus_if.abort = 1'b0;
`endif
        @(negedge clk);
        obs = {bus_if.ready, bus_if.busy, bus_if.done, bus_if.a_ready, bus_if.b_ready,
               bus_if.input_write, bus_if.row_ptr, bus_if.acc_clear, bus_if.enable,
               bus_if.output_write, bus_if.c_valid, bus_if.c_row_ptr, bus_if.c_last};
        checks++;
        assert (obs === IDLE_V) else begin
          failures++;
          $error("FAIL idle_after_cut observed=%b expected=%b", obs, IDLE_V);
        end
        break;
      end
    end
    bus_if.start = 1'b0;
    if (cut_kind == 0) begin
      checks++;
      assert (done_seen === want_done) else begin
        failures++;
        $error("FAIL done_cycle observed=%0d expected=%0d", done_seen, want_done);
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.num_tiles = '0;
    bus_if.a_valid   = 1'b0;
    bus_if.b_valid   = 1'b0;
    bus_if.c_ready   = 1'b0;
`ifdef SYSTOLIC_CTRL_ABORT_EN
    bus_if.abort     = 1'b0;
`endif
    @(negedge clk);
    checks++;
    assert ({bus_if.ready, bus_if.busy, bus_if.done, bus_if.a_ready, bus_if.b_ready,
             bus_if.input_write, bus_if.row_ptr, bus_if.acc_clear, bus_if.enable,
             bus_if.output_write, bus_if.c_valid, bus_if.c_row_ptr, bus_if.c_last} === IDLE_V)
    else begin
      failures++;
      $error("FAIL reset_state observed_ready=%b expected=1", bus_if.ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Single tile, no stalls: done at cycle 40.
    clear_gaps();
    build(1);
    run_job(-1, 0, 40);

    // Three-cycle operand gap at row 4 delays done by three.
    clear_gaps();
    gap_a[0][4] = 3;
    build(1);
    run_job(-1, 0, 43);

    // Three K-tiles accumulate: done at 72.
    clear_gaps();
    build(3);
    run_job(-1, 0, 72);

    // num_tiles = 0 behaves as one tile.
    clear_gaps();
    build(0);
    run_job(-1, 0, 40);

    // Result backpressure of five cycles on row 2.
    clear_gaps();
    gap_c[2] = 5;
    build(1);
    run_job(-1, 0, 45);

    // Reset during DRAIN aborts without done; the next job runs normally.
    clear_gaps();
    build(1);
    run_job(20, 1, -1);
    clear_gaps();
    build(1);
    run_job(-1, 0, 40);

`ifdef SYSTOLIC_CTRL_ABORT_EN
    // Abort on the third COMPUTE cycle, then a clean job.
    clear_gaps();
    build(1);
    run_job(11, 2, -1);
    clear_gaps();
    build(2);
    run_job(-1, 0, 56);
`endif

    // Randomised jobs: tile counts, operand gaps and result stalls.
    for (int j = 0; j < 6; j++) begin
      random_gaps();
      build(int'($urandom_range(0, 4)));
      run_job(-1, 0, exp_done_t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
